uart_cmd_bridge: RTL and testbench

Byte-level command decoder between the UART receiver/transmitter cores and the TPU programming ports. It parses host command frames into single-cycle write strobes for the unified buffer, weight memory and instruction memory, and issues UB readbacks and execution starts. It returns ACK, data and status bytes over a ready/valid TX port. Its write, read and start outputs drive the test-interface side of the `tpu_top` UB/weight/instruction mux directly.

---
 rtl/tpu_uart_pkg.sv | 40 ++++
 rtl/uart_cmd_tx_serializer.sv | 37 +++
 rtl/uart_cmd_bridge.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_cmd_bridge.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_uart_pkg.sv
// Shared opcodes, response bytes, payload lengths and FSM encoding for the UART command bridge.
package tpu_uart_pkg;

  localparam logic [7:0] OP_WR_UB    = 8'h01;
  localparam logic [7:0] OP_WR_WT    = 8'h02;
  localparam logic [7:0] OP_WR_INSTR = 8'h03;
  localparam logic [7:0] OP_RD_UB    = 8'h04;
  localparam logic [7:0] OP_START    = 8'h05;
  localparam logic [7:0] OP_STATUS   = 8'h06;

  localparam logic [7:0] ACK_BYTE = 8'h4B;
  localparam logic [7:0] ERR_BYTE = 8'hEE;

  localparam int UB_BYTES    = 32;
  localparam int WT_BYTES    = 8;
  localparam int INSTR_BYTES = 4;
  localparam int RD_BYTES    = 32;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR_LO  = 3'd1,
    ST_ADDR_HI  = 3'd2,
    ST_PAYLOAD  = 3'd3,
    ST_COMMIT   = 3'd4,
    ST_RD_ISSUE = 3'd5,
    ST_RD_WAIT  = 3'd6,
    ST_TX       = 3'd7
  } bridge_state_t;

  // Index of the final payload byte for a write opcode.
  function automatic logic [4:0] payload_last(input logic [7:0] op);
    case (op)
      OP_WR_UB:    payload_last = 5'(UB_BYTES - 1);
      OP_WR_WT:    payload_last = 5'(WT_BYTES - 1);
      OP_WR_INSTR: payload_last = 5'(INSTR_BYTES - 1);
      default:     payload_last = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/uart_cmd_tx_serializer.sv
// Response serializer: loads up to 32 bytes and shifts them out LSB-first over ready/valid.
module uart_cmd_tx_serializer
  import tpu_uart_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [255:0] load_word,
  input  logic [5:0]   load_count,
  input  logic         tx_ready,
  output logic         tx_valid,
  output logic [7:0]   tx_data,
  output logic         done
);

  logic [255:0] shreg_q;
  logic [5:0]   remain_q;

  assign tx_valid = (remain_q != 6'd0);
  assign tx_data  = shreg_q[7:0];
  assign done     = tx_valid && tx_ready && (remain_q == 6'd1);

  // Hold the current byte until it transfers, then shift in the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q  <= '0;
      remain_q <= '0;
    end else if (load) begin
      shreg_q  <= load_word;
      remain_q <= load_count;
    end else if (tx_valid && tx_ready) begin
      shreg_q  <= shreg_q >> 8;
      remain_q <= remain_q - 6'd1;
    end
  end

endmodule

// File: rtl/uart_cmd_bridge.sv
// Host command decoder: UART bytes in, TPU programming strobes and response bytes out.
//
// state      | meaning
// IDLE       | waiting for an opcode byte
// ADDR_LO    | collecting the address (low) byte
// ADDR_HI    | collecting the weight address high bits
// PAYLOAD    | collecting little-endian data bytes
// COMMIT     | one-cycle write or start strobe, queue ACK
// RD_ISSUE   | one-cycle UB read strobe
// RD_WAIT    | waiting out the UB read latency
// TX         | response bytes draining to the transmitter
module uart_cmd_bridge
  import tpu_uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int RD_LATENCY     = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rx_valid,
  input  logic [7:0]   rx_data,
  output logic         tx_valid,
  output logic [7:0]   tx_data,
  input  logic         tx_ready,
  output logic         ub_wr_en,
  output logic [7:0]   ub_wr_addr,
  output logic [255:0] ub_wr_data,
  output logic         ub_rd_en,
  output logic [7:0]   ub_rd_addr,
  input  logic [255:0] ub_rd_data,
  output logic         wt_wr_en,
  output logic [9:0]   wt_wr_addr,
  output logic [63:0]  wt_wr_data,
  output logic         instr_wr_en,
  output logic [4:0]   instr_wr_addr,
  output logic [31:0]  instr_wr_data,
  output logic         start_execution,
  input  logic         sys_busy,
  input  logic         vpu_busy,
  input  logic         ub_busy,
  input  logic         sys_done,
  input  logic         vpu_done,
  input  logic         ub_done,
  output logic [7:0]   debug_state,
  output logic [7:0]   debug_cmd,
  output logic [15:0]  debug_byte_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  bridge_state_t state_q, state_d;
  logic [7:0]    opcode_q;
  logic [9:0]    addr_q;
  logic [255:0]  data_q;
  logic [4:0]    byte_idx_q;
  logic [TW-1:0] to_cnt_q;
  logic [1:0]    rd_cnt_q;
  logic          timeout_q, overrun_q;
  logic [15:0]   byte_cnt_q;

  logic          in_frame, busy_rx, timeout_hit, status_clr;
  logic          ser_load, ser_done;
  logic [255:0]  ser_word;
  logic [5:0]    ser_count;
  logic [7:0]    status_byte;

  assign in_frame    = (state_q == ST_ADDR_LO) || (state_q == ST_ADDR_HI) || (state_q == ST_PAYLOAD);
  assign busy_rx     = (state_q == ST_COMMIT) || (state_q == ST_RD_ISSUE) ||
                       (state_q == ST_RD_WAIT) || (state_q == ST_TX);
  assign timeout_hit = in_frame && !rx_valid && (to_cnt_q == TW'(1));
  assign status_clr  = (state_q == ST_TX) && (opcode_q == OP_STATUS) && ser_done;
  assign status_byte = {overrun_q, timeout_q, ub_done, vpu_done, sys_done, ub_busy, vpu_busy, sys_busy};

  // Write and read ports share one address/data register; each port views its own width.
  assign ub_wr_addr       = addr_q[7:0];
  assign ub_wr_data       = data_q;
  assign ub_rd_addr       = addr_q[7:0];
  assign wt_wr_addr       = addr_q;
  assign wt_wr_data       = data_q[63:0];
  assign instr_wr_addr    = addr_q[4:0];
  assign instr_wr_data    = data_q[31:0];
  assign debug_state      = {5'd0, state_q};
  assign debug_cmd        = opcode_q;
  assign debug_byte_count = byte_cnt_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode, strobes and response loading.
  always_comb begin
    state_d         = state_q;
    ser_load        = 1'b0;
    ser_word        = '0;
    ser_count       = 6'd1;
    ub_wr_en        = 1'b0;
    wt_wr_en        = 1'b0;
    instr_wr_en     = 1'b0;
    ub_rd_en        = 1'b0;
    start_execution = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            OP_WR_UB, OP_WR_WT, OP_WR_INSTR, OP_RD_UB: state_d = ST_ADDR_LO;
            OP_START: state_d = ST_COMMIT;
            OP_STATUS: begin
              state_d       = ST_TX;
              ser_load      = 1'b1;
              ser_word[7:0] = status_byte;
            end
            default: begin
              state_d       = ST_TX;
              ser_load      = 1'b1;
              ser_word[7:0] = ERR_BYTE;
            end
          endcase
        end
      end
      ST_ADDR_LO: begin
        if (timeout_hit) state_d = ST_IDLE;
        else if (rx_valid) begin
          if (opcode_q == OP_WR_WT)      state_d = ST_ADDR_HI;
          else if (opcode_q == OP_RD_UB) state_d = ST_RD_ISSUE;
          else                           state_d = ST_PAYLOAD;
        end
      end
      ST_ADDR_HI: begin
        if (timeout_hit)   state_d = ST_IDLE;
        else if (rx_valid) state_d = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (timeout_hit) state_d = ST_IDLE;
        else if (rx_valid && (byte_idx_q == payload_last(opcode_q))) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        case (opcode_q)
          OP_WR_UB:    ub_wr_en        = 1'b1;
          OP_WR_WT:    wt_wr_en        = 1'b1;
          OP_WR_INSTR: instr_wr_en     = 1'b1;
          OP_START:    start_execution = 1'b1;
          default:     ;
        endcase
        state_d       = ST_TX;
        ser_load      = 1'b1;
        ser_word[7:0] = ACK_BYTE;
      end
      ST_RD_ISSUE: begin
        ub_rd_en = 1'b1;
        state_d  = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (rd_cnt_q == 2'd0) begin
          state_d   = ST_TX;
          ser_load  = 1'b1;
          ser_word  = ub_rd_data;
          ser_count = 6'(RD_BYTES);
        end
      end
      ST_TX: begin
        if (ser_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Frame capture, idle timer, read-latency timer, sticky flags and byte counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q   <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      byte_idx_q <= '0;
      to_cnt_q   <= TW'(TIMEOUT_CYCLES);
      rd_cnt_q   <= '0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
      byte_cnt_q <= '0;
    end else begin
      if (rx_valid) byte_cnt_q <= byte_cnt_q + 16'd1;

      if (rx_valid || !in_frame)    to_cnt_q <= TW'(TIMEOUT_CYCLES);
      else if (to_cnt_q != '0)      to_cnt_q <= to_cnt_q - TW'(1);

      case (state_q)
        ST_IDLE: if (rx_valid) begin
          opcode_q   <= rx_data;
          byte_idx_q <= '0;
        end
        ST_ADDR_LO:  if (rx_valid) addr_q <= {2'b00, rx_data};
        ST_ADDR_HI:  if (rx_valid) addr_q[9:8] <= rx_data[1:0];
        ST_PAYLOAD:  if (rx_valid) begin
          data_q[{byte_idx_q, 3'b000} +: 8] <= rx_data;
          byte_idx_q <= byte_idx_q + 5'd1;
        end
        ST_RD_ISSUE: rd_cnt_q <= 2'(RD_LATENCY - 1);
        ST_RD_WAIT:  if (rd_cnt_q != 2'd0) rd_cnt_q <= rd_cnt_q - 2'd1;
        default: ;
      endcase

      // A new event in the same cycle as the clearing transfer wins.
      if (timeout_hit)            timeout_q <= 1'b1;
      else if (status_clr)        timeout_q <= 1'b0;
      if (rx_valid && busy_rx)    overrun_q <= 1'b1;
      else if (status_clr)        overrun_q <= 1'b0;
    end
  end

  uart_cmd_tx_serializer u_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (ser_load),
    .load_word  (ser_word),
    .load_count (ser_count),
    .tx_ready   (tx_ready),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .done       (ser_done)
  );

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Directed bench for uart_cmd_bridge with a frame-level scoreboard model.
module tb_uart_cmd_bridge;

  localparam int TO  = 40;
  localparam int RDL = 1;
  localparam int K_UB = 0, K_WT = 1, K_INSTR = 2, K_START = 3, K_RD = 4;

  typedef struct {
    int         kind;
    logic [9:0] addr;
    logic [255:0] data;
    int         cyc;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         rx_valid = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         tx_valid;
  logic [7:0]   tx_data;
  logic         tx_ready = 1'b1;
  logic         ub_wr_en, ub_rd_en, wt_wr_en, instr_wr_en, start_execution;
  logic [7:0]   ub_wr_addr, ub_rd_addr;
  logic [255:0] ub_wr_data;
  logic [255:0] ub_rd_data;
  logic [9:0]   wt_wr_addr;
  logic [63:0]  wt_wr_data;
  logic [4:0]   instr_wr_addr;
  logic [31:0]  instr_wr_data;
  logic [5:0]   stat_in = 6'd0;
  logic [7:0]   debug_state, debug_cmd;
  logic [15:0]  debug_byte_count;

  uart_cmd_bridge #(.TIMEOUT_CYCLES(TO), .RD_LATENCY(RDL)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .ub_wr_en(ub_wr_en), .ub_wr_addr(ub_wr_addr), .ub_wr_data(ub_wr_data),
    .ub_rd_en(ub_rd_en), .ub_rd_addr(ub_rd_addr), .ub_rd_data(ub_rd_data),
    .wt_wr_en(wt_wr_en), .wt_wr_addr(wt_wr_addr), .wt_wr_data(wt_wr_data),
    .instr_wr_en(instr_wr_en), .instr_wr_addr(instr_wr_addr), .instr_wr_data(instr_wr_data),
    .start_execution(start_execution),
    .sys_busy(stat_in[0]), .vpu_busy(stat_in[1]), .ub_busy(stat_in[2]),
    .sys_done(stat_in[3]), .vpu_done(stat_in[4]), .ub_done(stat_in[5]),
    .debug_state(debug_state), .debug_cmd(debug_cmd), .debug_byte_count(debug_byte_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Unified buffer peripheral: written by the DUT, read with one cycle of latency.
  logic [255:0] ub_periph [256];
  always @(posedge clk) begin
    if (ub_wr_en) ub_periph[ub_wr_addr] <= ub_wr_data;
    if (ub_rd_en) ub_rd_data <= ub_periph[ub_rd_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input bit ok, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Scoreboard state.
  ev_t          exp_ev[$];
  logic [7:0]   exp_tx[$];
  int           exp_start[$];
  logic [255:0] ub_mem [256];
  logic [7:0]   frame_q[$];
  bit           m_timeout = 0, m_overrun = 0;
  int           nbytes = 0;
  int           last_drive = 0;

  // Observations captured by the compare process.
  bit           prev_valid = 0, hold_pending = 0;
  logic [7:0]   hold_data = 8'h00;
  int           tx_xfers = 0;
  logic [7:0]   last_tx = 8'h00;
  logic [7:0]   last_ub_addr = 8'h00;
  logic [255:0] last_ub_data = '0;
  logic [9:0]   last_wt_addr = '0;
  logic [63:0]  last_wt_data = '0;
  logic [4:0]   last_instr_addr = '0;
  logic [31:0]  last_instr_data = '0;

  // Compare DUT strobes and TX stream against the model every cycle.
  always @(negedge clk) begin
    int           nstb, kind;
    logic [9:0]   a;
    logic [255:0] d;
    ev_t          e;
    logic [7:0]   b;
    if (!rst_n) begin
      prev_valid   = 0;
      hold_pending = 0;
    end else begin
      nstb = int'(ub_wr_en) + int'(ub_rd_en) + int'(wt_wr_en) + int'(instr_wr_en) + int'(start_execution);
      if (nstb > 1) check("strobe_exclusive", 0, 256'(nstb), 256'd1);
      if (nstb != 0) begin
        kind = 0; a = '0; d = '0;
        if (ub_wr_en) begin kind = K_UB; a = {2'b00, ub_wr_addr}; d = ub_wr_data;
          last_ub_addr = ub_wr_addr; last_ub_data = ub_wr_data; end
        else if (wt_wr_en) begin kind = K_WT; a = wt_wr_addr; d = {192'd0, wt_wr_data};
          last_wt_addr = wt_wr_addr; last_wt_data = wt_wr_data; end
        else if (instr_wr_en) begin kind = K_INSTR; a = {5'd0, instr_wr_addr}; d = {224'd0, instr_wr_data};
          last_instr_addr = instr_wr_addr; last_instr_data = instr_wr_data; end
        else if (start_execution) kind = K_START;
        else begin kind = K_RD; a = {2'b00, ub_rd_addr}; end
        if (exp_ev.size() == 0) check("strobe_unexpected", 0, 256'(kind), 256'hFF);
        else begin
          e = exp_ev.pop_front();
          check("strobe_kind_addr_cycle", (kind == e.kind) && (a === e.addr) && (cyc == e.cyc),
                {192'd0, 8'(kind), 6'd0, a, 32'(cyc)}, {192'd0, 8'(e.kind), 6'd0, e.addr, 32'(e.cyc)});
          if (kind == K_UB || kind == K_WT || kind == K_INSTR)
            check("strobe_data", d === e.data, d, e.data);
        end
      end
      if (hold_pending)
        check("tx_stall_stable", tx_valid && (tx_data === hold_data), {247'd0, tx_valid, tx_data}, {247'd0, 1'b1, hold_data});
      if (tx_valid && !prev_valid) begin
        if (exp_start.size() == 0) check("tx_start_unexpected", 0, 256'(cyc), 256'd0);
        else begin
          kind = exp_start.pop_front();
          check("tx_start_cycle", cyc == kind, 256'(cyc), 256'(kind));
        end
      end
      if (tx_valid && tx_ready) begin
        tx_xfers++;
        last_tx = tx_data;
        if (exp_tx.size() == 0) check("tx_unexpected", 0, 256'(tx_data), 256'h100);
        else begin
          b = exp_tx.pop_front();
          check("tx_byte", tx_data === b, 256'(tx_data), 256'(b));
        end
      end
      hold_pending = tx_valid && !tx_ready;
      hold_data    = tx_data;
      prev_valid   = tx_valid;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid   = 1'b1;
    rx_data    = b;
    last_drive = cyc;
    nbytes++;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  // Send frame_q and record what a correct bridge must do in response.
  task automatic send_frame();
    logic [7:0]   op, hi;
    logic [255:0] w;
    ev_t          e;
    bit           has_ev;
    int           st;
    op = frame_q[0];
    foreach (frame_q[i]) send_byte(frame_q[i]);
    w = '0; has_ev = 1;
    e.kind = K_START; e.addr = '0; e.data = '0; e.cyc = last_drive + 1;
    st = last_drive + 2;
    case (op)
      8'h01: begin
        for (int i = 0; i < 32; i++) w[i*8 +: 8] = frame_q[2+i];
        e.kind = K_UB; e.addr = {2'b00, frame_q[1]}; e.data = w;
        ub_mem[frame_q[1]] = w;
        exp_tx.push_back(8'h4B);
      end
      8'h02: begin
        for (int i = 0; i < 8; i++) w[i*8 +: 8] = frame_q[3+i];
        hi = frame_q[2];
        e.kind = K_WT; e.addr = {hi[1:0], frame_q[1]}; e.data = w;
        exp_tx.push_back(8'h4B);
      end
      8'h03: begin
        for (int i = 0; i < 4; i++) w[i*8 +: 8] = frame_q[2+i];
        hi = frame_q[1];
        e.kind = K_INSTR; e.addr = {5'd0, hi[4:0]}; e.data = w;
        exp_tx.push_back(8'h4B);
      end
      8'h04: begin
        e.kind = K_RD; e.addr = {2'b00, frame_q[1]};
        w = ub_mem[frame_q[1]];
        for (int i = 0; i < 32; i++) exp_tx.push_back(w[i*8 +: 8]);
        st = last_drive + 2 + RDL;
      end
      8'h05: exp_tx.push_back(8'h4B);
      8'h06: begin
        has_ev = 0;
        exp_tx.push_back({m_overrun, m_timeout, stat_in});
        m_overrun = 0; m_timeout = 0;
        st = last_drive + 1;
      end
      default: begin
        has_ev = 0;
        exp_tx.push_back(8'hEE);
        st = last_drive + 1;
      end
    endcase
    if (has_ev) exp_ev.push_back(e);
    exp_start.push_back(st);
  endtask

  task automatic drain(input string name);
    int i;
    for (i = 0; i < 3000; i++) begin
      if (exp_tx.size() == 0 && exp_ev.size() == 0 && exp_start.size() == 0) break;
      @(posedge clk);
    end
    check(name, i < 3000, 256'(exp_tx.size() + exp_ev.size()), 256'd0);
    repeat (2) @(posedge clk);
    #1;
    check({name, "_idle"}, debug_state == 8'd0, 256'(debug_state), 256'd0);
  endtask

  function automatic bit outs_zero();
    return (|{tx_valid, tx_data, ub_wr_en, ub_wr_addr, ub_wr_data, ub_rd_en, ub_rd_addr,
              wt_wr_en, wt_wr_addr, wt_wr_data, instr_wr_en, instr_wr_addr, instr_wr_data,
              start_execution, debug_state, debug_cmd, debug_byte_count}) == 1'b0;
  endfunction

  initial begin
    int base;
    #1 rst_n = 1'b0;
    #2 check("reset_outputs", outs_zero(), 256'(debug_state), 256'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // WR_UB 0x10 with bytes 00..1F
    frame_q = {8'h01, 8'h10};
    for (int i = 0; i < 32; i++) frame_q.push_back(8'(i));
    send_frame();
    drain("wr_ub");
    check("wr_ub_addr", last_ub_addr == 8'h10, 256'(last_ub_addr), 256'h10);
    check("wr_ub_byte0", last_ub_data[7:0] == 8'h00, 256'(last_ub_data[7:0]), 256'h00);
    check("wr_ub_byte31", last_ub_data[255:248] == 8'h1F, 256'(last_ub_data[255:248]), 256'h1F);
    check("wr_ub_ack", last_tx == 8'h4B, 256'(last_tx), 256'h4B);

    // RD_UB 0x10 with a 5-cycle stall mid-stream
    base = tx_xfers;
    frame_q = {8'h04, 8'h10};
    send_frame();
    for (int i = 0; i < 500 && tx_xfers < base + 10; i++) @(posedge clk);
    #1 tx_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 tx_ready = 1'b1;
    drain("rd_ub");
    check("rd_ub_count", tx_xfers - base == 32, 256'(tx_xfers - base), 256'd32);
    check("rd_ub_last", last_tx == 8'h1F, 256'(last_tx), 256'h1F);

    // WR_WT at 0x3FF, WR_INSTR at 0x25 -> 0x05
    frame_q = {8'h02, 8'hFF, 8'h03, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    send_frame();
    drain("wr_wt");
    check("wr_wt_addr", last_wt_addr == 10'h3FF, 256'(last_wt_addr), 256'h3FF);
    check("wr_wt_data", last_wt_data == 64'h1817161514131211, 256'(last_wt_data), 256'h1817161514131211);
    frame_q = {8'h03, 8'h25, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_frame();
    drain("wr_instr");
    check("wr_instr_addr", last_instr_addr == 5'h05, 256'(last_instr_addr), 256'h05);
    check("wr_instr_data", last_instr_data == 32'hDDCCBBAA, 256'(last_instr_data), 256'hDDCCBBAA);

    // Timeout after a partial WR_UB
    stat_in = 6'b010101;
    send_byte(8'h01); send_byte(8'h10);
    for (int i = 0; i < 5; i++) send_byte(8'h80 + 8'(i));
    repeat (35) @(posedge clk);
    #1 check("timeout_not_yet", debug_state == 8'd3, 256'(debug_state), 256'd3);
    repeat (6) @(posedge clk);
    #1 check("timeout_abort", debug_state == 8'd0, 256'(debug_state), 256'd0);
    m_timeout = 1;
    frame_q = {8'h06};
    send_frame();
    drain("status_to");
    check("status_to_set", last_tx == 8'h55, 256'(last_tx), 256'h55);
    send_frame();
    drain("status_to2");
    check("status_to_clear", last_tx == 8'h15, 256'(last_tx), 256'h15);

    // Unknown opcode, then START
    frame_q = {8'h7F};
    send_frame();
    drain("unknown");
    check("unknown_err", last_tx == 8'hEE, 256'(last_tx), 256'hEE);
    check("unknown_cmd", debug_cmd == 8'h7F, 256'(debug_cmd), 256'h7F);
    frame_q = {8'h05};
    send_frame();
    drain("start");
    check("start_ack", last_tx == 8'h4B, 256'(last_tx), 256'h4B);

    // Overrun: byte arrives while the START ACK is stalled
    tx_ready = 1'b0;
    frame_q = {8'h05};
    send_frame();
    repeat (3) @(posedge clk);
    send_byte(8'h55);
    m_overrun = 1;
    repeat (2) @(posedge clk);
    #1 tx_ready = 1'b1;
    drain("overrun_start");
    check("overrun_cmd", debug_cmd == 8'h05, 256'(debug_cmd), 256'h05);
    stat_in = 6'b101010;
    frame_q = {8'h06};
    send_frame();
    drain("status_ovr");
    check("status_ovr_set", last_tx == 8'hAA, 256'(last_tx), 256'hAA);
    check("byte_count", debug_byte_count == 16'(nbytes), 256'(debug_byte_count), 256'(nbytes));

    // Reset in the middle of a payload
    send_byte(8'h01); send_byte(8'h20);
    for (int i = 0; i < 3; i++) send_byte(8'h60 + 8'(i));
    check("mid_payload_state", debug_state == 8'd3, 256'(debug_state), 256'd3);
    #3 rst_n = 1'b0;
    #1 check("mid_reset_outputs", outs_zero(), 256'(debug_state), 256'd0);
    nbytes = 0; m_timeout = 0; m_overrun = 0;
    exp_tx.delete(); exp_ev.delete(); exp_start.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    frame_q = {8'h01, 8'h20};
    for (int i = 0; i < 32; i++) frame_q.push_back(8'hA0 + 8'(i));
    send_frame();
    drain("wr_ub_post_reset");
    frame_q = {8'h04, 8'h20};
    send_frame();
    drain("rd_ub_post_reset");
    check("post_reset_last", last_tx == 8'hBF, 256'(last_tx), 256'hBF);
    check("post_reset_count", debug_byte_count == 16'(nbytes), 256'(debug_byte_count), 256'(nbytes));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
